video_pattern_checker: RTL

VIDEO_PATTERN_CHECKER -- requirements
Module: video_pattern_checker

---
 rtl/video_pattern_pkg.sv | 22 ++
 rtl/bar_color_lut.sv | 23 ++
 rtl/video_pattern_checker.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_pkg.sv
// rtl/video_pattern_pkg.sv - Shared FSM encoding, colour-bar constants and rgb field widths.
package video_pattern_pkg;

    localparam int COMP_W    = 8;
    localparam int RGB_W     = 3 * COMP_W;
    localparam int BAR_COUNT = 8;
    localparam int BAR_IDX_W = 3;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

endpackage

// File: rtl/bar_color_lut.sv
// rtl/bar_color_lut.sv - Combinational bar-index to colour decode, shared by generator and checker.
module bar_color_lut
    import video_pattern_pkg::*;
(
    input  logic [BAR_IDX_W-1:0] bar_i,
    output logic [RGB_W-1:0]     color_o
);

    always_comb begin
        color_o = BAR_BLACK;
        case (bar_i)
            3'd0:    color_o = BAR_WHITE;
            3'd1:    color_o = BAR_YELLOW;
            3'd2:    color_o = BAR_CYAN;
            3'd3:    color_o = BAR_GREEN;
            3'd4:    color_o = BAR_MAGENTA;
            3'd5:    color_o = BAR_RED;
            3'd6:    color_o = BAR_BLUE;
            default: color_o = BAR_BLACK;
        endcase
    end

endmodule

// File: rtl/video_pattern_checker.sv
// rtl/video_pattern_checker.sv - Colour-bar checker with geometry lock; VPC_ERR_CAPTURE_EN adds first-error capture.
module video_pattern_checker
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 de,
    input  logic                 vsync,
    input  logic [RGB_W-1:0]     rgb,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 frame_done,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [ERR_WIDTH-1:0] frame_count
`ifdef VPC_ERR_CAPTURE_EN
    ,
    output logic [15:0]          err_x,
    output logic [15:0]          err_y,
    output logic [RGB_W-1:0]     err_rgb,
    output logic                 err_valid
`endif
);

    localparam int POS_W = 16;
    localparam int BAR_W = H_ACTIVE / BAR_COUNT;
    localparam logic [POS_W-1:0] H_LIM   = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_LIM   = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] BAR_END = POS_W'(BAR_W - 1);

    logic                 vsync_q, de_q;
    logic [POS_W-1:0]     x_q, x_d, y_q, y_d;
    logic [POS_W-1:0]     bar_pos_q, bar_pos_d;
    logic [BAR_IDX_W-1:0] bar_q, bar_d;
    logic                 line_bad_q, line_bad_d;
    logic [1:0]           state_q, state_d;
    logic                 mismatch_q, frame_done_q;
    logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
    logic [ERR_WIDTH-1:0] frame_count_q, frame_count_d;

    logic                 vsync_rise, de_fall, frame_ok, overflow;
    logic [POS_W-1:0]     pix_x, pix_pos;
    logic [BAR_IDX_W-1:0] pix_bar;
    logic [RGB_W-1:0]     exp_rgb;
    logic                 compare_en, pix_bad, frame_pass;

    assign vsync_rise = vsync & ~vsync_q;
    assign de_fall    = ~de & de_q;
    assign frame_ok   = (y_q == V_LIM) && !line_bad_q;

    // Position tracking; a vsync rise in the same cycle as de makes this pixel x=0 of line 0.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        line_bad_d = line_bad_q;
        bar_d      = bar_q;
        bar_pos_d  = bar_pos_q;
        pix_x      = x_q;
        pix_bar    = bar_q;
        pix_pos    = bar_pos_q;
        if (vsync_rise) begin
            x_d        = '0;
            y_d        = '0;
            line_bad_d = 1'b0;
            bar_d      = '0;
            bar_pos_d  = '0;
            pix_x      = '0;
            pix_bar    = '0;
            pix_pos    = '0;
        end else if (de_fall) begin
            x_d       = '0;
            bar_d     = '0;
            bar_pos_d = '0;
            y_d       = (y_q == '1) ? y_q : y_q + POS_W'(1);
            if (x_q != H_LIM) begin
                line_bad_d = 1'b1;
            end
        end
        if (de) begin
            x_d = (pix_x == '1) ? pix_x : pix_x + POS_W'(1);
            if (pix_pos == BAR_END) begin
                bar_pos_d = '0;
                bar_d     = pix_bar + BAR_IDX_W'(1);
            end else begin
                bar_pos_d = pix_pos + POS_W'(1);
            end
        end
    end

    assign overflow = (x_d > H_LIM) || (y_d > V_LIM);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: begin
                if (vsync_rise) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (vsync_rise && frame_ok) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (vsync_rise) begin
                    if (!frame_ok) state_d = ST_SEARCH;
                end else if (overflow) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    bar_color_lut u_lut (
        .bar_i   (pix_bar),
        .color_o (exp_rgb)
    );

    // Pixels past the line end have no defined colour; overflow handles them instead.
    assign compare_en = (state_q == ST_LOCKED) && de && (pix_x < H_LIM);
    assign pix_bad    = compare_en && (rgb != exp_rgb);
    assign frame_pass = (state_q == ST_LOCKED) && vsync_rise && frame_ok;

    assign err_count_d   = (pix_bad && (err_count_q != '1)) ? err_count_q + ERR_WIDTH'(1) : err_count_q;
    assign frame_count_d = frame_pass ? frame_count_q + ERR_WIDTH'(1) : frame_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            bar_q         <= '0;
            bar_pos_q     <= '0;
            line_bad_q    <= 1'b0;
            state_q       <= ST_SEARCH;
            mismatch_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            err_count_q   <= '0;
            frame_count_q <= '0;
        end else begin
            vsync_q       <= vsync;
            de_q          <= de;
            x_q           <= x_d;
            y_q           <= y_d;
            bar_q         <= bar_d;
            bar_pos_q     <= bar_pos_d;
            line_bad_q    <= line_bad_d;
            state_q       <= state_d;
            mismatch_q    <= pix_bad;
            frame_done_q  <= frame_pass;
            err_count_q   <= err_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign mismatch    = mismatch_q;
    assign frame_done  = frame_done_q;
    assign err_count   = err_count_q;
    assign frame_count = frame_count_q;

`ifdef VPC_ERR_CAPTURE_EN
    logic [POS_W-1:0] pix_y;
    logic [15:0]      err_x_q, err_y_q;
    logic [RGB_W-1:0] err_rgb_q;
    logic             err_valid_q;

    assign pix_y = vsync_rise ? '0 : y_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_x_q     <= '0;
            err_y_q     <= '0;
            err_rgb_q   <= '0;
            err_valid_q <= 1'b0;
        end else if (pix_bad && !err_valid_q) begin
            err_x_q     <= pix_x;
            err_y_q     <= pix_y;
            err_rgb_q   <= rgb;
            err_valid_q <= 1'b1;
        end
    end

    assign err_x     = err_x_q;
    assign err_y     = err_y_q;
    assign err_rgb   = err_rgb_q;
    assign err_valid = err_valid_q;
`else
    // Default build carries no first-error capture state.
`endif

endmodule
